// File: rtl/mario_sprite_fetcher.sv
// Sprite line fetcher: during horizontal blank, copies one 21-pixel row of the
// sprite ROM into a line buffer, then overlays it on the next displayed line.
// Optional macro MARIO_SPRITE_MIRROR_EN adds facing_left (horizontal mirroring).
module mario_sprite_fetcher (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
`ifdef MARIO_SPRITE_MIRROR_EN
  input  logic        facing_left,
`endif
  input  logic        line_start,
  input  logic [9:0]  next_y,
  input  logic [9:0]  DrawX,
  output logic [8:0]  rom_addr,
  input  logic [23:0] rom_color,
  output logic        pixel_valid,
  output logic [23:0] pixel_color,
  output logic        busy
);

  localparam int          SPR_W  = 21;
  localparam logic [23:0] TRANSP = 24'h800080;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      state_q;
  logic [4:0]  col_q, row_q;
  logic        line_hit_q, line_hit_d;
  logic [9:0]  pos_x_q, pos_y_q;
  logic [SPR_W-1:0] opaque_q;
  logic [23:0] color_q [SPR_W];
  logic        pixel_valid_q, pixel_valid_d;
  logic [23:0] pixel_color_q, pixel_color_d;

  logic [9:0]  pos_y_eff, row_w, dx;
  logic        hit, last_col, fetch_en, in_range, pix_hit;
  logic [4:0]  col_eff, idx;

  // A frame_start coinciding with line_start must already see the new sprite_y.
  assign pos_y_eff = frame_start ? sprite_y : pos_y_q;
  assign row_w     = next_y - pos_y_eff;
  assign hit       = (next_y >= pos_y_eff) && (row_w <= 10'd20);
  assign last_col  = (col_q == 5'd20);
  assign fetch_en  = (state_q == FETCH) && !line_start;

`ifdef MARIO_SPRITE_MIRROR_EN
  logic mirror_q;
  always_ff @(posedge Clk) begin
    if (Reset)            mirror_q <= 1'b0;
    else if (frame_start) mirror_q <= facing_left;
  end
  assign col_eff = mirror_q ? (5'd20 - col_q) : col_q;
`else
  assign col_eff = col_q;
`endif

  assign busy     = (state_q == FETCH);
  assign rom_addr = busy ? ({4'd0, row_q} * 9'd21 + {4'd0, col_eff}) : 9'd0;

  always_comb begin
    line_hit_d = line_hit_q;
    if (line_start)                line_hit_d = 1'b0;
    else if (fetch_en && last_col) line_hit_d = 1'b1;
  end

  assign dx       = DrawX - pos_x_q;
  assign in_range = (DrawX >= pos_x_q) && (dx <= 10'd20);
  assign idx      = in_range ? dx[4:0] : 5'd0;
  // Requiring the hit flag both now and next cycle keeps pixel_valid low
  // in any cycle where busy is high.
  assign pix_hit       = line_hit_q && line_hit_d && in_range && opaque_q[idx];
  assign pixel_valid_d = pix_hit;
  assign pixel_color_d = pix_hit ? color_q[idx] : 24'h000000;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      col_q         <= 5'd0;
      row_q         <= 5'd0;
      line_hit_q    <= 1'b0;
      pos_x_q       <= 10'd0;
      pos_y_q       <= 10'd0;
      opaque_q      <= '0;
      pixel_valid_q <= 1'b0;
      pixel_color_q <= 24'h000000;
    end else begin
      if (frame_start) begin
        pos_x_q <= sprite_x;
        pos_y_q <= sprite_y;
      end
      line_hit_q    <= line_hit_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_color_q <= pixel_color_d;
      if (fetch_en) opaque_q[col_q] <= (rom_color != TRANSP);
      case (state_q)
        IDLE: begin
          if (line_start && hit) begin
            state_q <= FETCH;
            col_q   <= 5'd0;
            row_q   <= row_w[4:0];
          end
        end
        FETCH: begin
          if (line_start) begin
            state_q <= hit ? FETCH : IDLE;
            col_q   <= 5'd0;
            if (hit) row_q <= row_w[4:0];
          end else if (last_col) begin
            state_q <= IDLE;
            col_q   <= 5'd0;
          end else begin
            col_q <= col_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Colour storage is pure data; opaque bits alone decide visibility.
  always_ff @(posedge Clk) begin
    if (fetch_en) color_q[col_q] <= rom_color;
  end

  assign pixel_valid = pixel_valid_q;
  assign pixel_color = pixel_color_q;

endmodule

// File: tb/tb_mario_sprite_fetcher.sv
// Self-checking bench for mario_sprite_fetcher with a behavioural sprite ROM.
module tb_mario_sprite_fetcher;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  sprite_x = '0, sprite_y = '0;
  logic        line_start = 1'b0;
  logic [9:0]  next_y = '0, DrawX = '0;
  logic [8:0]  rom_addr;
  logic [23:0] rom_color;
  logic        pixel_valid, busy;
  logic [23:0] pixel_color;
`ifdef MARIO_SPRITE_MIRROR_EN
  logic        facing_left = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0]  addr_q[$];
  logic [24:0] pix_q[$];

  always #5 Clk = ~Clk;

  mario_sprite_fetcher dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
`ifdef MARIO_SPRITE_MIRROR_EN
    .facing_left(facing_left),
`endif
    .line_start(line_start), .next_y(next_y), .DrawX(DrawX),
    .rom_addr(rom_addr), .rom_color(rom_color),
    .pixel_valid(pixel_valid), .pixel_color(pixel_color), .busy(busy)
  );

  function automatic logic [23:0] rom_f(input int a);
    if (a == 105)         return 24'hF83800;
    else if (a % 21 == 3) return 24'h800080;
    else                  return {8'h12, 7'h00, 9'(a)};
  endfunction

  always_comb rom_color = rom_f(int'(rom_addr));

  // Expected {valid, color} for a line buffer holding ROM row `row`.
  function automatic logic [24:0] exp_pix(input int drawx, input int px,
                                          input int row, input bit hit, input bit mir);
    int d;
    logic [23:0] c;
    d = drawx - px;
    if (!hit || d < 0 || d > 20) return 25'd0;
    c = rom_f(row * 21 + (mir ? 20 - d : d));
    if (c == 24'h800080) return 25'd0;
    return {1'b1, c};
  endfunction

  task automatic push_fetch(input int base, input bit mir);
    for (int i = 0; i < 21; i++) addr_q.push_back(9'(mir ? base + 20 - i : base + i));
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    n_tests++;
    if ({busy, rom_addr, pixel_valid, pixel_color} !== 35'd0)
      begin n_fail++; $display("FAIL reset_state got busy=%b addr=%0d pv=%b pc=%h want all 0", busy, rom_addr, pixel_valid, pixel_color); end
  endtask

  task automatic test_fetch();
    int n = 0;
    int dxs[7] = '{100, 103, 121, 99, 110, 120, 101};
    logic [24:0] e;
    @(negedge Clk); frame_start = 1'b1; sprite_x = 10'd100; sprite_y = 10'd50;
    @(negedge Clk); frame_start = 1'b0;
    push_fetch(105, 1'b0);
    line_start = 1'b1; next_y = 10'd55;
    @(negedge Clk); line_start = 1'b0;
    while (busy && n < 40) begin
      n_tests++;
      if (addr_q.size() == 0) begin n_fail++; $display("FAIL fetch_addr extra cycle addr=%0d", rom_addr); end
      else begin
        e = 25'(addr_q.pop_front());
        if (rom_addr !== e[8:0]) begin n_fail++; $display("FAIL fetch_addr got %0d want %0d", rom_addr, e[8:0]); end
      end
      n++; @(negedge Clk);
    end
    n_tests++;
    if (n != 21 || addr_q.size() != 0) begin n_fail++; $display("FAIL fetch_len got %0d cycles want 21", n); end
    addr_q.delete();
    n_tests++;
    if (busy !== 1'b0 || rom_addr !== 9'd0) begin n_fail++; $display("FAIL idle_after_fetch busy=%b addr=%0d want 0/0", busy, rom_addr); end
    sprite_x = 10'd0; sprite_y = 10'd0;  // not latched: must not move the sprite
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk); DrawX = 10'(dxs[i]); pix_q.push_back(exp_pix(dxs[i], 100, 5, 1'b1, 1'b0));
      @(negedge Clk); e = pix_q.pop_front(); n_tests++;
      if ({pixel_valid, pixel_color} !== e)
        begin n_fail++; $display("FAIL pixel DrawX=%0d got %b/%h want %b/%h", dxs[i], pixel_valid, pixel_color, e[24], e[23:0]); end
    end
  endtask

  task automatic test_miss();
    int ys[2] = '{49, 71};
    int n = 0;
    logic [24:0] e;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk); line_start = 1'b1; next_y = 10'(ys[k]); DrawX = 10'd100;
      for (int j = 0; j < 3; j++) begin
        @(negedge Clk); line_start = 1'b0; n_tests++;
        if (busy !== 1'b0 || rom_addr !== 9'd0 || pixel_valid !== 1'b0)
          begin n_fail++; $display("FAIL miss y=%0d busy=%b addr=%0d pv=%b want 0", ys[k], busy, rom_addr, pixel_valid); end
      end
      for (int d = 100; d <= 120; d += 5) begin
        @(negedge Clk); DrawX = 10'(d); pix_q.push_back(25'd0);
        @(negedge Clk); e = pix_q.pop_front(); n_tests++;
        if ({pixel_valid, pixel_color} !== e) begin n_fail++; $display("FAIL miss_pixel DrawX=%0d got %b/%h want 0", d, pixel_valid, pixel_color); end
      end
    end
    // row 20 is the last hitting row
    @(negedge Clk); push_fetch(420, 1'b0); line_start = 1'b1; next_y = 10'd70;
    @(negedge Clk); line_start = 1'b0;
    while (busy && n < 40) begin
      n_tests++; e = 25'(addr_q.size() ? addr_q.pop_front() : 9'h1FF);
      if (rom_addr !== e[8:0]) begin n_fail++; $display("FAIL row20_addr got %0d want %0d", rom_addr, e[8:0]); end
      n++; @(negedge Clk);
    end
    n_tests++;
    if (n != 21) begin n_fail++; $display("FAIL row20_len got %0d want 21", n); end
    addr_q.delete();
    for (int d = 100; d <= 104; d++) begin
      @(negedge Clk); DrawX = 10'(d); pix_q.push_back(exp_pix(d, 100, 20, 1'b1, 1'b0));
      @(negedge Clk); e = pix_q.pop_front(); n_tests++;
      if ({pixel_valid, pixel_color} !== e) begin n_fail++; $display("FAIL row20_pixel DrawX=%0d got %b/%h want %b/%h", d, pixel_valid, pixel_color, e[24], e[23:0]); end
    end
  endtask

  task automatic test_abort();
    int n = 0;
    logic [24:0] e;
    @(negedge Clk); DrawX = 10'd100; push_fetch(105, 1'b0); line_start = 1'b1; next_y = 10'd55;
    @(negedge Clk); line_start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      n_tests++; e = 25'(addr_q.pop_front());
      if (rom_addr !== e[8:0] || pixel_valid !== 1'b0 || busy !== 1'b1)
        begin n_fail++; $display("FAIL abort_pre k=%0d addr=%0d want %0d pv=%b busy=%b", k, rom_addr, e[8:0], pixel_valid, busy); end
      if (k < 10) @(negedge Clk);
    end
    addr_q.delete();
    push_fetch(210, 1'b0); line_start = 1'b1; next_y = 10'd60;
    @(negedge Clk); line_start = 1'b0;
    while (busy && n < 40) begin
      n_tests++; e = 25'(addr_q.size() ? addr_q.pop_front() : 9'h1FF);
      if (rom_addr !== e[8:0] || pixel_valid !== 1'b0)
        begin n_fail++; $display("FAIL abort_restart got addr=%0d pv=%b want %0d/0", rom_addr, pixel_valid, e[8:0]); end
      n++; @(negedge Clk);
    end
    n_tests++;
    if (n != 21) begin n_fail++; $display("FAIL abort_len got %0d want 21", n); end
    addr_q.delete();
    for (int d = 100; d <= 102; d++) begin
      @(negedge Clk); DrawX = 10'(d); pix_q.push_back(exp_pix(d, 100, 10, 1'b1, 1'b0));
      @(negedge Clk); e = pix_q.pop_front(); n_tests++;
      if ({pixel_valid, pixel_color} !== e) begin n_fail++; $display("FAIL abort_pixel DrawX=%0d got %b/%h want %b/%h", d, pixel_valid, pixel_color, e[24], e[23:0]); end
    end
  endtask

  task automatic test_same_cycle();
    int n = 0;
    int dxs[4] = '{300, 303, 320, 299};
    logic [24:0] e;
    @(negedge Clk); frame_start = 1'b1; sprite_x = 10'd300; sprite_y = 10'd200;
    line_start = 1'b1; next_y = 10'd205; push_fetch(105, 1'b0);
    @(negedge Clk); frame_start = 1'b0; line_start = 1'b0;
    while (busy && n < 40) begin
      n_tests++; e = 25'(addr_q.size() ? addr_q.pop_front() : 9'h1FF);
      if (rom_addr !== e[8:0]) begin n_fail++; $display("FAIL same_cycle_addr got %0d want %0d", rom_addr, e[8:0]); end
      n++; @(negedge Clk);
    end
    n_tests++;
    if (n != 21) begin n_fail++; $display("FAIL same_cycle_len got %0d want 21", n); end
    addr_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk); DrawX = 10'(dxs[i]); pix_q.push_back(exp_pix(dxs[i], 300, 5, 1'b1, 1'b0));
      @(negedge Clk); e = pix_q.pop_front(); n_tests++;
      if ({pixel_valid, pixel_color} !== e) begin n_fail++; $display("FAIL same_cycle_pixel DrawX=%0d got %b/%h want %b/%h", dxs[i], pixel_valid, pixel_color, e[24], e[23:0]); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [24:0] e;
    int dxs[3] = '{300, 0, 5};
    @(negedge Clk); line_start = 1'b1; next_y = 10'd205;
    @(negedge Clk); line_start = 1'b0;
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || rom_addr !== 9'd0) begin n_fail++; $display("FAIL reset_abort busy=%b addr=%0d want 0/0", busy, rom_addr); end
    // re-latch the old position; the partial line must stay hidden
    @(negedge Clk); frame_start = 1'b1; sprite_x = 10'd300; sprite_y = 10'd200;
    @(negedge Clk); frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); DrawX = 10'(dxs[i]); pix_q.push_back(25'd0);
      @(negedge Clk); e = pix_q.pop_front(); n_tests++;
      if ({pixel_valid, pixel_color} !== e) begin n_fail++; $display("FAIL reset_partial DrawX=%0d got %b/%h want 0", dxs[i], pixel_valid, pixel_color); end
    end
  endtask

`ifdef MARIO_SPRITE_MIRROR_EN
  task automatic test_mirror();
    int n = 0;
    logic [24:0] e;
    @(negedge Clk); frame_start = 1'b1; facing_left = 1'b1; sprite_x = 10'd100; sprite_y = 10'd50;
    @(negedge Clk); frame_start = 1'b0; facing_left = 1'b0;
    push_fetch(0, 1'b1); line_start = 1'b1; next_y = 10'd50;
    @(negedge Clk); line_start = 1'b0;
    while (busy && n < 40) begin
      n_tests++; e = 25'(addr_q.size() ? addr_q.pop_front() : 9'h1FF);
      if (rom_addr !== e[8:0]) begin n_fail++; $display("FAIL mirror_addr got %0d want %0d", rom_addr, e[8:0]); end
      n++; @(negedge Clk);
    end
    n_tests++;
    if (n != 21) begin n_fail++; $display("FAIL mirror_len got %0d want 21", n); end
    addr_q.delete();
    for (int d = 100; d <= 120; d += 17) begin
      @(negedge Clk); DrawX = 10'(d); pix_q.push_back(exp_pix(d, 100, 0, 1'b1, 1'b1));
      @(negedge Clk); e = pix_q.pop_front(); n_tests++;
      if ({pixel_valid, pixel_color} !== e) begin n_fail++; $display("FAIL mirror_pixel DrawX=%0d got %b/%h want %b/%h", d, pixel_valid, pixel_color, e[24], e[23:0]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_miss();
    test_abort();
    test_same_cycle();
    test_reset_mid_fetch();
`ifdef MARIO_SPRITE_MIRROR_EN
    test_reset();
    test_mirror();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
